load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_lane_align.sv | 50 +++++
 rtl/load_store_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the request legality check used at acceptance.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } lsu_state_t;

  // Misaligned half/word and the reserved size are all rejected.
  function automatic logic req_is_error(input logic [1:0] size,
                                        input logic [1:0] addr_lo);
    logic err;
    case (size)
      SZ_BYTE: err = 1'b0;
      SZ_HALF: err = addr_lo[0];
      SZ_WORD: err = (addr_lo != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: extracts/extends load data from a memory word
// and merges store data into the read word for sub-word writes.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        sign_ext,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;
  logic [31:0] byte_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] byte_mask;
  logic [31:0] half_mask;

  assign byte_shift = {addr_lo, 3'b000};
  assign half_shift = {addr_lo[1], 4'b0000};
  assign byte_word  = rword >> byte_shift;
  assign byte_sel   = byte_word[7:0];
  assign half_sel   = addr_lo[1] ? rword[31:16] : rword[15:0];
  assign byte_mask  = 32'h0000_00FF << byte_shift;
  assign half_mask  = 32'h0000_FFFF << half_shift;

  always_comb begin
    load_data = rword;
    merged    = wdata;
    case (size)
      SZ_BYTE: begin
        load_data = sign_ext ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
        merged    = (rword & ~byte_mask) | ((wdata & 32'h0000_00FF) << byte_shift);
      end
      SZ_HALF: begin
        load_data = sign_ext ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
        merged    = (rword & ~half_mask) | ((wdata & 32'h0000_FFFF) << half_shift);
      end
      default: begin
        load_data = rword;
        merged    = wdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: single outstanding CPU access to a word memory with
// sub-word loads, read-modify-write sub-word stores and alignment checking.
//
// state | meaning
// IDLE  | ready for a request
// READ  | memory word addressed; load data or RMW merge captured
// WRITE | single-cycle mem_WE pulse with the final word
// RESP  | response held until resp_ready
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic                  mem_WE,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_t            state, state_next;
  logic                  accept;
  logic                  req_err;
  logic                  write_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [1:0]            addr_lo_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic                  resp_error_q;
  logic [31:0]           load_data;
  logic [31:0]           merged;

  assign req_err = req_is_error(req_size, req_addr[1:0]);

  lsu_lane_align u_lane_align (
    .size      (size_q),
    .addr_lo   (addr_lo_q),
    .sign_ext  (signed_q),
    .rword     (mem_rdata),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = (state == IDLE);
    accept     = req_valid && (state == IDLE);
    mem_WE     = (state == WRITE);
    resp_valid = (state == RESP);
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                  state_next = RESP;
          else if (!req_write)          state_next = READ;
          else if (req_size == SZ_WORD) state_next = WRITE;
          else                          state_next = READ;
        end
      end
      READ:    state_next = write_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Response registers only change on acceptance or in READ, so they stay
  // stable for the whole RESP backpressure window.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      write_q      <= 1'b0;
      size_q       <= SZ_BYTE;
      signed_q     <= 1'b0;
      addr_lo_q    <= 2'b00;
      wdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else if (accept) begin
      write_q      <= req_write;
      size_q       <= req_size;
      signed_q     <= req_signed;
      addr_lo_q    <= req_addr[1:0];
      wdata_q      <= req_wdata;
      mem_addr_q   <= req_addr >> 2;
      mem_wdata_q  <= req_wdata;
      resp_rdata_q <= '0;
      resp_error_q <= req_err;
    end else if (state == READ) begin
      if (write_q) mem_wdata_q  <= merged;
      else         resp_rdata_q <= load_data;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;

endmodule
